// File: rtl/sram_like_ram_ctrl.sv
// SRAM-like slave in front of a single-port synchronous RAM: in-order data_ok per accepted
// request, a small response FIFO, and optional LFSR-driven handshake stalls.
module sram_like_ram_ctrl #(
    parameter int          RAM_AW     = 18,
    parameter int          BUF_DEPTH  = 4,
    parameter int          RAND_STALL = 0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);
    localparam int PW = $clog2(BUF_DEPTH);

    // Handshake: a request transfers on any cycle with req && addr_ok; data_ok is a one-cycle
    // pulse carrying one response and cannot be back-pressured by the CPU.

    logic [31:0]       mem [0:(1 << RAM_AW) - 1];
    logic [31:0]       ram_dout;
    logic [RAM_AW-1:0] ram_idx;
    logic [3:0]        lane_mask;
    logic [3:0]        wen;
    logic              accept;

    logic              s1_valid;
    logic              s1_wr;
    logic [31:0]       s1_resp;

    logic [31:0]       fifo [0:BUF_DEPTH-1];
    logic [PW:0]       wr_ptr;
    logic [PW:0]       rd_ptr;
    logic [PW:0]       fifo_count;
    logic              fifo_empty;
    logic [PW+1:0]     outstanding;
    logic              push;
    logic              pop;

    logic [15:0]       lfsr;
    logic              stall_a;
    logic              stall_d;
    logic              unused_addr;

    assign unused_addr = ^addr[31:RAM_AW+2];

    assign stall_a = (RAND_STALL != 0) && lfsr[0] && lfsr[1];
    assign stall_d = (RAND_STALL != 0) && lfsr[2] && lfsr[3];

    assign ram_idx     = addr[RAM_AW+1:2];
    assign fifo_count  = wr_ptr - rd_ptr;
    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign outstanding = {1'b0, fifo_count} + {{(PW + 1){1'b0}}, s1_valid};

    assign addr_ok = !reset && (outstanding < (PW + 2)'(BUF_DEPTH)) && !stall_a;
    assign accept  = req && addr_ok;

    always_comb begin
        lane_mask = 4'b1111;
        case (size)
            2'd0:    lane_mask = 4'b0001 << addr[1:0];
            2'd1:    lane_mask = addr[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    end

    assign wen = wstrb & lane_mask;

    // FIFO head wins over the stage-1 response; stage-1 only bypasses an empty FIFO.
    assign s1_resp = s1_wr ? 32'h0 : ram_dout;
    assign data_ok = !reset && !stall_d && (!fifo_empty || s1_valid);
    assign rdata   = !data_ok    ? 32'h0 :
                     !fifo_empty ? fifo[rd_ptr[PW-1:0]] : s1_resp;
    assign pop     = data_ok && !fifo_empty;
    assign push    = s1_valid && !(fifo_empty && data_ok);

    // RAM contents are deliberately not reset so completed writes survive a reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (wen[b]) mem[ram_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end else begin
                ram_dout <= mem[ram_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr[PW-1:0]] <= s1_resp;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_wr    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            lfsr     <= LFSR_SEED;
        end else begin
            lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            s1_valid <= accept;
            if (accept) s1_wr <= wr;
            if (push)   wr_ptr <= wr_ptr + (PW + 1)'(1);
            if (pop)    rd_ptr <= rd_ptr + (PW + 1)'(1);
        end
    end
endmodule

// File: tb/tb_sram_like_ram_ctrl.sv
// Bench for sram_like_ram_ctrl: directed vectors plus a reference memory and in-order
// response queue checked on every data_ok.
module tb_sram_like_ram_ctrl;
    localparam int RAM_AW    = 12;
    localparam int BUF_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    sram_like_ram_ctrl #(
        .RAM_AW    (RAM_AW),
        .BUF_DEPTH (BUF_DEPTH),
        .RAND_STALL(1),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .wr     (wr),
        .size   (size),
        .wstrb  (wstrb),
        .addr   (addr),
        .wdata  (wdata),
        .addr_ok(addr_ok),
        .data_ok(data_ok),
        .rdata  (rdata)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          checks = 0;
    int          passed = 0;
    int          acc_cnt = 0;
    int          resp_cnt = 0;
    int          max_out = 0;
    int          max_lat = 0;
    logic [31:0] last_rdata = 32'h0;
    logic [31:0] exp_q[$];
    int          acc_cyc_q[$];
    logic [31:0] mem_m [int];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (acc_cnt - resp_cnt > max_out) max_out = acc_cnt - resp_cnt;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act === req_v) passed++;
        else $display("FAIL %s: got %h, required %h", name, act, req_v);
    endtask

    // Reference model of one accepted request: byte-lane update of the memory and the
    // response it must eventually produce.
    task automatic model_accept(input logic w, input logic [1:0] s, input logic [3:0] st,
                                input logic [31:0] a, input logic [31:0] d);
        int          idx;
        int          nbytes;
        int          base;
        logic [31:0] word;
        idx    = int'(a[RAM_AW+1:2]);
        nbytes = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        base   = int'(a[1:0]) / nbytes * nbytes;
        if (w) begin
            word = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
            for (int b = base; b < base + nbytes; b++) begin
                if (st[b]) word[8*b +: 8] = d[8*b +: 8];
            end
            mem_m[idx] = word;
            exp_q.push_back(32'h0);
        end else begin
            exp_q.push_back(mem_m.exists(idx) ? mem_m[idx] : 32'hx);
        end
        acc_cyc_q.push_back(cyc);
        acc_cnt++;
    endtask

    task automatic do_req(input logic w, input logic [1:0] s, input logic [3:0] st,
                          input logic [31:0] a, input logic [31:0] d, output int waits);
        bit done;
        done  = 1'b0;
        waits = 0;
        req = 1'b1; wr = w; size = s; wstrb = st; addr = a; wdata = d;
        while (!done) begin
            @(negedge clk);
            if (addr_ok) begin
                model_accept(w, s, st, a, d);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (!done) begin
                waits++;
                if (waits > 200) begin
                    checks++;
                    $display("FAIL accept_timeout: no addr_ok after %0d cycles, required within 200", waits);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        req = 1'b0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    // Compare process: every data_ok must match the oldest expected response.
    always @(negedge clk) begin
        logic [31:0] e;
        int          a;
        if (reset) begin
            check("reset_addr_ok", {31'b0, addr_ok}, 32'h0);
            check("reset_data_ok", {31'b0, data_ok}, 32'h0);
            check("reset_rdata", rdata, 32'h0);
        end else if (data_ok) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_data_ok: got rdata %h, required no response", rdata);
            end else begin
                e = exp_q.pop_front();
                a = acc_cyc_q.pop_front();
                check("rdata", rdata, e);
                if (cyc - a > max_lat) max_lat = cyc - a;
            end
            last_rdata = rdata;
            resp_cnt++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $display("%0d/%0d checks passed", passed, checks);
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        int a0;
        int r0;
        force dut.stall_a = 1'b0;
        force dut.stall_d = 1'b0;

        // Reset held 3 cycles with req asserted; first cycle after release accepts.
        reset = 1'b1; req = 1'b1; wr = 1'b1; size = 2'd2; wstrb = 4'hF; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        do_req(1'b1, 2'd2, 4'hF, 32'h0, 32'h0, w);
        check("accept_first_cycle_after_reset", w, 0);
        idle(2);

        // Word write then read, both answered the next cycle.
        max_lat = 0;
        r0 = resp_cnt;
        do_req(1'b1, 2'd2, 4'hF, 32'h1000, 32'hDEADBEEF, w);
        do_req(1'b0, 2'd2, 4'hF, 32'h1000, 32'h0, w);
        idle(3);
        check("t2_resp_count", resp_cnt - r0, 2);
        check("t2_latency", max_lat, 1);
        check("t2_read_data", last_rdata, 32'hDEADBEEF);

        // Sub-word stores, including strobes outside the access lanes.
        do_req(1'b1, 2'd0, 4'b0100, 32'h1002, 32'h00AA0000, w);
        do_req(1'b0, 2'd2, 4'hF, 32'h1000, 32'h0, w);
        idle(3);
        check("t3_byte_store", last_rdata, 32'hDEAABEEF);
        do_req(1'b1, 2'd1, 4'b0011, 32'h1000, 32'h00001234, w);
        do_req(1'b0, 2'd2, 4'hF, 32'h1000, 32'h0, w);
        idle(3);
        check("t3_half_store", last_rdata, 32'hDEAA1234);
        do_req(1'b1, 2'd0, 4'hF, 32'h1003, 32'h11223344, w);
        do_req(1'b0, 2'd0, 4'hF, 32'h1001, 32'h0, w);
        idle(3);
        check("t3_byte_lane_masked", last_rdata, 32'h11AA1234);
        do_req(1'b1, 2'd1, 4'hF, 32'h1002, 32'h55667788, w);
        do_req(1'b0, 2'd2, 4'hF, 32'h1000, 32'h0, w);
        idle(3);
        check("t3_upper_half_masked", last_rdata, 32'h55661234);

        // Back-to-back reads with data_ok stalled: accepts stop at the buffer depth.
        for (int i = 0; i < 8; i++) do_req(1'b1, 2'd2, 4'hF, 32'h3000 + 4 * i, 32'hC0DE0000 + i, w);
        idle(3);
        force dut.stall_d = 1'b1;
        a0 = acc_cnt;
        r0 = resp_cnt;
        fork
            begin
                int wi;
                for (int i = 0; i < 8; i++) do_req(1'b0, 2'd2, 4'hF, 32'h3000 + 4 * i, 32'h0, wi);
                req = 1'b0;
            end
            begin
                repeat (10) @(posedge clk);
                #2;
                check("t4_accepts_while_stalled", acc_cnt - a0, BUF_DEPTH);
                check("t4_addr_ok_low_when_full", {31'b0, addr_ok}, 32'h0);
                check("t4_no_data_ok_while_stalled", resp_cnt - r0, 0);
                force dut.stall_d = 1'b0;
            end
        join
        wait_drain();
        check("t4_resp_count", resp_cnt - r0, 8);
        check("t4_last_in_order", last_rdata, 32'hC0DE0007);

        // Reset with responses in flight: none may come back, RAM keeps its data.
        force dut.stall_d = 1'b1;
        for (int i = 0; i < 3; i++) do_req(1'b0, 2'd2, 4'hF, 32'h3000 + 4 * i, 32'h0, w);
        req = 1'b0;
        reset = 1'b1;
        exp_q.delete();
        acc_cyc_q.delete();
        acc_cnt = resp_cnt;
        r0 = resp_cnt;
        repeat (2) @(posedge clk);
        #1;
        force dut.stall_d = 1'b0;
        reset = 1'b0;
        idle(10);
        check("t6_no_stale_data_ok", resp_cnt - r0, 0);
        do_req(1'b0, 2'd2, 4'hF, 32'h1000, 32'h0, w);
        idle(3);
        check("t6_ram_kept_1000", last_rdata, 32'h55661234);
        do_req(1'b0, 2'd2, 4'hF, 32'h3004, 32'h0, w);
        idle(3);
        check("t6_ram_kept_3004", last_rdata, 32'hC0DE0001);

        // Random traffic with LFSR stalls active.
        release dut.stall_a;
        release dut.stall_d;
        for (int i = 0; i < 16; i++) do_req(1'b1, 2'd2, 4'hF, 32'h2000 + 4 * i, $urandom, w);
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 7) == 0) idle(1);
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                   32'h2000 + 32'($urandom_range(0, 63)), $urandom, w);
        end
        wait_drain();
        check("t5_accept_eq_resp", acc_cnt - resp_cnt, 0);
        check("t5_outstanding_bound", {31'b0, max_out <= BUF_DEPTH}, 32'h1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
